// File: rtl/icache_pkg.sv
// icache_pkg: shared FSM state encoding, line geometry and bus request tag constants.
package icache_pkg;
   typedef enum logic [2:0] {IDLE, LOOKUP, MISS_REQ, MISS_FILL, RESP} state_t;
   localparam int LINE_BYTES = 64;
   localparam int BEATS = 8;
   localparam int BEAT_W = 64;
   localparam logic READ = 1'b1;
   localparam logic [3:0] MEMORY = 4'h1;
   localparam logic [12:0] REQ_TAG = {READ, MEMORY, 8'h00};
endpackage

// File: rtl/icache_array.sv
// icache_array: direct-mapped tag/valid/data storage, one async read port, one write port, bulk valid clear.
module icache_array #(
   parameter int SETS = 64,
   parameter int IDX_W = 6,
   parameter int TAG_W = 52,
   parameter int LINE_W = 512
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic              rd_valid,
   output logic [TAG_W-1:0]  rd_tag,
   output logic [LINE_W-1:0] rd_data,
   input  logic              we,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [TAG_W-1:0]  wr_tag,
   input  logic              wr_valid,
   input  logic [LINE_W-1:0] wr_data,
   input  logic              clr_all
);
   logic [SETS-1:0]   valid;
   logic [TAG_W-1:0]  tags [SETS];
   logic [LINE_W-1:0] data [SETS];
   assign rd_valid = valid[rd_idx];
   assign rd_tag = tags[rd_idx];
   assign rd_data = data[rd_idx];
   always_ff @(posedge clk or negedge reset)
      if (!reset) valid <= '0;
      else if (clr_all) valid <= '0;
      else if (we) valid[wr_idx] <= wr_valid;
   // tag and data contents are deliberately left unreset; valid bits gate their use
   always_ff @(posedge clk)
      if (we) begin
         tags[wr_idx] <= wr_tag;
         data[wr_idx] <= wr_data;
      end
endmodule

// File: rtl/icache.sv
// icache: direct-mapped instruction cache, one outstanding line fill over an 8-beat 64-bit bus.
module icache #(
   parameter int SETS = 64,
   parameter int LINE_BYTES = 64
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    ic_enable,
   input  logic [63:0]             iaddr,
   input  logic                    inv_all,
   output logic [8*LINE_BYTES-1:0] idata,
   output logic                    ic_done,
   output logic                    bus_reqcyc,
   output logic [63:0]             bus_req,
   output logic [12:0]             bus_reqtag,
   input  logic                    bus_reqack,
   input  logic                    bus_respcyc,
   input  logic [63:0]             bus_resp,
   output logic                    bus_respack
);
   import icache_pkg::*;
   localparam int OFF_W = $clog2(LINE_BYTES);
   localparam int IDX_W = $clog2(SETS);
   localparam int TAG_W = 64 - OFF_W - IDX_W;
   localparam int LINE_W = 8 * LINE_BYTES;
   state_t state, state_nx;
   logic [63:0] addr_q;
   logic [2:0] beat_q;
   logic pend_inv;
   logic [LINE_W-BEAT_W-1:0] line_buf;
   logic [LINE_W-1:0] fill_line, rd_data;
   logic [TAG_W-1:0] rd_tag;
   logic rd_valid, hit, last_beat, we, clr_all;
   assign hit = rd_valid && rd_tag == addr_q[63 -: TAG_W];
   assign last_beat = bus_respcyc && beat_q == 3'(BEATS - 1);
   assign fill_line = {bus_resp, line_buf};
   assign we = state == MISS_FILL && last_beat;
   // an invalidate seen during a fill is deferred until the line has been returned
   assign clr_all = (state == IDLE && inv_all) || (state == RESP && (pend_inv || inv_all));
   assign bus_req = addr_q;
   assign bus_reqtag = REQ_TAG;
   assign bus_respack = bus_respcyc;
   icache_array #(
      .SETS(SETS), .IDX_W(IDX_W), .TAG_W(TAG_W), .LINE_W(LINE_W)
   ) u_array (
      .clk(clk),
      .reset(reset),
      .rd_idx(addr_q[OFF_W +: IDX_W]),
      .rd_valid(rd_valid),
      .rd_tag(rd_tag),
      .rd_data(rd_data),
      .we(we),
      .wr_idx(addr_q[OFF_W +: IDX_W]),
      .wr_tag(addr_q[63 -: TAG_W]),
      .wr_valid(!(pend_inv || inv_all)),
      .wr_data(fill_line),
      .clr_all(clr_all)
   );
   always_ff @(posedge clk or negedge reset)
      if (!reset) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:      state_nx = ic_enable ? LOOKUP : IDLE;
         LOOKUP:    state_nx = hit ? RESP : MISS_REQ;
         MISS_REQ:  state_nx = bus_reqack ? MISS_FILL : MISS_REQ;
         MISS_FILL: state_nx = last_beat ? RESP : MISS_FILL;
         RESP:      state_nx = IDLE;
         default:   state_nx = IDLE;
      endcase
   end
   always_comb begin
      ic_done = state == RESP;
      bus_reqcyc = state == MISS_REQ;
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         addr_q <= '0;
         beat_q <= '0;
         pend_inv <= 1'b0;
         idata <= '0;
      end else begin
         if (state == IDLE && ic_enable) addr_q <= iaddr & ~64'(LINE_BYTES - 1);
         if (state == LOOKUP && hit) idata <= rd_data;
         if (we) idata <= fill_line;
         if (state == MISS_FILL && bus_respcyc) beat_q <= beat_q + 3'd1;
         pend_inv <= state != IDLE && state != RESP && (pend_inv || inv_all);
      end
   always_ff @(posedge clk)
      if (state == MISS_FILL && bus_respcyc)
         for (int k = 0; k < BEATS - 1; k++)
            if (beat_q == 3'(k)) line_buf[k*BEAT_W +: BEAT_W] <= bus_resp;
endmodule

// File: tb/tb_icache.sv
// tb_icache: directed self-checking bench for icache covering miss, hit, conflict, backpressure, invalidate and reset.
module tb_icache;
   logic clk, reset, ic_enable, inv_all, bus_reqack, bus_respcyc;
   logic [63:0] iaddr, bus_resp, bus_req;
   logic [511:0] idata;
   logic ic_done, bus_reqcyc, bus_respack;
   logic [12:0] bus_reqtag;
   int errors = 0, checks = 0;

   icache dut (
      .clk(clk), .reset(reset), .ic_enable(ic_enable), .iaddr(iaddr), .inv_all(inv_all),
      .idata(idata), .ic_done(ic_done), .bus_reqcyc(bus_reqcyc), .bus_req(bus_req),
      .bus_reqtag(bus_reqtag), .bus_reqack(bus_reqack), .bus_respcyc(bus_respcyc),
      .bus_resp(bus_resp), .bus_respack(bus_respack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [511:0] mk(input logic [63:0] base);
      logic [511:0] l;
      for (int k = 0; k < 8; k++) l[64*k +: 64] = base + 64'(k);
      return l;
   endfunction

   task automatic hit(input logic [63:0] a, input logic [511:0] exp);
      ic_enable = 1'b1;
      iaddr = a;
      tick();
      ic_enable = 1'b0;
      chk("hit_lookup_done", ic_done, 0);
      chk("hit_lookup_reqcyc", bus_reqcyc, 0);
      tick();
      chk("hit_done", ic_done, 1);
      chk("hit_idata", idata, exp);
      chk("hit_reqcyc", bus_reqcyc, 0);
      tick();
      chk("hit_done_pulse", ic_done, 0);
   endtask

   task automatic miss(input logic [63:0] a, input logic [63:0] base, input int delay,
                       input int inv_beat, input bit inv_en);
      logic [511:0] exp;
      logic [63:0] line_a;
      exp = mk(base);
      line_a = a & ~64'h3f;
      ic_enable = 1'b1;
      iaddr = a;
      inv_all = inv_en;
      tick();
      ic_enable = 1'b0;
      inv_all = 1'b0;
      chk("miss_lookup_done", ic_done, 0);
      tick();
      for (int i = 0; i < delay; i++) begin
         chk("bp_reqcyc", bus_reqcyc, 1);
         chk("bp_req", bus_req, line_a);
         ic_enable = i[0];
         iaddr = 64'h1000;
         tick();
      end
      ic_enable = 1'b0;
      chk("miss_reqcyc", bus_reqcyc, 1);
      chk("miss_req", bus_req, line_a);
      chk("miss_reqtag", bus_reqtag, 13'h1100);
      bus_reqack = 1'b1;
      tick();
      bus_reqack = 1'b0;
      chk("fill_reqcyc_drop", bus_reqcyc, 0);
      for (int k = 0; k < 8; k++) begin
         bus_respcyc = 1'b1;
         bus_resp = base + 64'(k);
         inv_all = (k == inv_beat);
         ic_enable = delay > 0;
         iaddr = 64'h2000;
         #1;
         chk("fill_respack", bus_respack, 1);
         chk("fill_done", ic_done, 0);
         tick();
      end
      bus_respcyc = 1'b0;
      inv_all = 1'b0;
      ic_enable = 1'b0;
      chk("miss_done", ic_done, 1);
      chk("miss_idata", idata, exp);
      tick();
      chk("miss_done_pulse", ic_done, 0);
      chk("miss_idata_hold", idata, exp);
   endtask

   initial begin
      reset = 1'b0;
      ic_enable = 1'b0;
      inv_all = 1'b0;
      iaddr = '0;
      bus_reqack = 1'b0;
      bus_respcyc = 1'b0;
      bus_resp = '0;
      #3;
      chk("rst_done", ic_done, 0);
      chk("rst_reqcyc", bus_reqcyc, 0);
      chk("rst_req", bus_req, 0);
      chk("rst_idata", idata, 0);
      @(negedge clk);
      reset = 1'b1;
      tick();
      miss(64'h1000, 64'h0, 0, -1, 1'b0);
      hit(64'h1008, mk(64'h0));
      miss(64'h2000, 64'h200, 0, -1, 1'b0);
      miss(64'h1000, 64'h100, 0, -1, 1'b0);
      hit(64'h1000, mk(64'h100));
      miss(64'h4048, 64'h400, 5, -1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("ignored_en_reqcyc", bus_reqcyc, 0);
         chk("ignored_en_done", ic_done, 0);
      end
      hit(64'h4040, mk(64'h400));
      miss(64'h3000, 64'h300, 0, 3, 1'b0);
      miss(64'h3000, 64'h310, 0, -1, 1'b0);
      miss(64'h4040, 64'h410, 0, -1, 1'b0);
      hit(64'h4040, mk(64'h410));
      miss(64'h4040, 64'h420, 0, -1, 1'b1);
      miss(64'h1000, 64'h110, 0, -1, 1'b0);
      hit(64'h1010, mk(64'h110));
      ic_enable = 1'b1;
      iaddr = 64'h2000;
      tick();
      ic_enable = 1'b0;
      tick();
      chk("abort_reqcyc", bus_reqcyc, 1);
      bus_reqack = 1'b1;
      tick();
      bus_reqack = 1'b0;
      for (int k = 0; k < 4; k++) begin
         bus_respcyc = 1'b1;
         bus_resp = 64'h900 + 64'(k);
         tick();
      end
      bus_respcyc = 1'b0;
      #2 reset = 1'b0;
      #1;
      chk("abort_rst_reqcyc", bus_reqcyc, 0);
      chk("abort_rst_done", ic_done, 0);
      chk("abort_rst_req", bus_req, 0);
      chk("abort_rst_idata", idata, 0);
      @(negedge clk);
      reset = 1'b1;
      tick();
      for (int k = 4; k < 8; k++) begin
         bus_respcyc = 1'b1;
         bus_resp = 64'h900 + 64'(k);
         #1;
         chk("stray_respack", bus_respack, 1);
         tick();
         chk("stray_done", ic_done, 0);
         chk("stray_reqcyc", bus_reqcyc, 0);
      end
      bus_respcyc = 1'b0;
      miss(64'h1000, 64'hA00, 0, -1, 1'b0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
